gshare_branch_predictor: RTL and testbench
==========================================

// Module: gshare_branch_predictor
// PURPOSE
//  Next-generation conditional-branch predictor for the SSOOO core: a table of
//  CTR_W-bit saturating counters indexed by PC, optionally XORed with a speculative
//  global history register (GHR). Predicts beq/bne at decode (combinational) and
//  trains at commit. Restores GHR from the committed snapshot on misprediction.
//  Replaces the single global counter; the pipeline carries Predict_index/Predict_ghr to commit.
// PARAMETERS
//  IDX_W      6   log2 of table entries (64 counters)
//  CTR_W      2   counter width; predict taken when counter MSB = 1
//  HIST_W     6   GHR width; must be <= IDX_W
//  GSHARE     1   1: index = PC-bits ^ GHR; 0: index = PC-bits (bimodal, GHR still maintained)
//  PC_W       32  program-counter width
//  PC_SHIFT   0   low PC bits dropped before indexing
//  INIT_CTR   1   counter reset value (weakly not-taken for CTR_W=2)
// PORTS
//  clk             in   1       clock, rising edge
//  rst             in   1       async, active-high reset
//  Decoded_opcode  in   12      opcode in decode; beq/bne encodings from opcodes.txt
//  Decoded_PC      in   PC_W    PC of decoded instruction
//  Decode_stall    in   1       decode held this cycle; no speculative GHR update
//  predicted       out  1       1 = predict taken (0 for non-branch)
//  Predict_index   out  IDX_W   table index used; travels with the branch
//  Predict_ghr     out  HIST_W  GHR value before this branch's shift; travels with branch
//  Commit_opcode   in   12      opcode at commit
//  Commit_index    in   IDX_W   Predict_index carried to commit
//  Commit_ghr      in   HIST_W  Predict_ghr carried to commit
//  Commit_taken    in   1       resolved outcome
//  Wrong_prediction in  1       committed branch mispredicted; pipeline flushes
//  mispredict_cnt  out  16      saturating count of committed mispredictions
// BEHAVIOUR
//  - Reset (async): every counter = INIT_CTR, GHR = 0, mispredict_cnt = 0; while rst=1 predicted = 0.
//  - dec_br = Decoded_opcode in {beq,bne}; com_br = Commit_opcode in {beq,bne}.
//  - pc_bits = Decoded_PC[PC_SHIFT+IDX_W-1:PC_SHIFT]; Predict_index = GSHARE ?
//    pc_bits ^ {{(IDX_W-HIST_W){0}},GHR} : pc_bits. Predict_ghr = GHR. Both combinational.
//  - predicted = dec_br & table[Predict_index][CTR_W-1] & ~rst; zero-cycle latency.
//  - Training at posedge, when com_br: table[Commit_index] += 1 if Commit_taken, saturating at
//    2^CTR_W-1; -= 1 if not taken, saturating at 0. Non-branch commits: no table change.
//  - GHR update priority per posedge (highest first):
//    1. com_br & Wrong_prediction: GHR <= {Commit_ghr[HIST_W-2:0], Commit_taken}; decode shift dropped.
//    2. dec_br & ~Decode_stall: GHR <= {GHR[HIST_W-2:0], predicted}.
//    3. else GHR holds.
//  - Wrong_prediction with non-branch Commit_opcode is ignored (no GHR, counter or stat change).
//  - Same-cycle commit write and decode read of one entry: decode sees the pre-write value (no bypass).
//  - mispredict_cnt += 1 on each com_br & Wrong_prediction; holds at 16'hFFFF.
//  - Decode_stall suppresses only the GHR shift; predicted still valid during stall.
//  - Table: one write port, one read port; registers or distributed RAM, no read latency.
// TESTING
//  1 Reset, beq at PC=0x10, GSHARE=0 -> predicted=0, Predict_index=0x10, counter reads 1.
//  2 Commit beq idx 5 taken x3 -> counter 1->2->3->3 (saturates); decode PC=5 -> predicted=1.
//  3 Commit bne idx 5 not-taken x4 from 3 -> 2,1,0,0; predicted=0 after second commit.
//  4 GSHARE=1, GHR=0: decode 3 unstalled taken-predicted branches -> GHR=6'b000111;
//    assert Decode_stall on a 4th -> GHR unchanged.
//  5 GHR=6'b101010, same cycle decode beq + commit bne Wrong_prediction=1,
//    Commit_ghr=6'b000011, Commit_taken=0 -> GHR=6'b000110; mispredict_cnt += 1.
//  6 Assert rst mid-sequence (async, between edges) -> predicted=0 immediately; all counters 1,
//    GHR=0, mispredict_cnt=0 after release.

Source files
------------

// File: rtl/gshare_branch_predictor_if.sv
// Decode/commit port bundle between the pipeline and the gshare predictor.
// The pipeline side is the master and the predictor side is the slave.
interface gshare_branch_predictor_if #(
  parameter int IDX_W  = 6,
  parameter int HIST_W = 6,
  parameter int PC_W   = 32
);
  logic [11:0]       Decoded_opcode;
  logic [PC_W-1:0]   Decoded_PC;
  logic              Decode_stall;
  logic              predicted;
  logic [IDX_W-1:0]  Predict_index;
  logic [HIST_W-1:0] Predict_ghr;
  logic [11:0]       Commit_opcode;
  logic [IDX_W-1:0]  Commit_index;
  logic [HIST_W-1:0] Commit_ghr;
  logic              Commit_taken;
  logic              Wrong_prediction;
  logic [15:0]       mispredict_cnt;

  modport master (
    output Decoded_opcode, Decoded_PC, Decode_stall,
    output Commit_opcode, Commit_index, Commit_ghr, Commit_taken, Wrong_prediction,
    input  predicted, Predict_index, Predict_ghr, mispredict_cnt
  );

  modport slave (
    input  Decoded_opcode, Decoded_PC, Decode_stall,
    input  Commit_opcode, Commit_index, Commit_ghr, Commit_taken, Wrong_prediction,
    output predicted, Predict_index, Predict_ghr, mispredict_cnt
  );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Gshare/bimodal conditional-branch predictor: combinational prediction at decode,
// counter training at commit, and GHR repair from the committed snapshot on a flush.
module gshare_branch_predictor #(
  parameter int          IDX_W    = 6,
  parameter int          CTR_W    = 2,
  parameter int          HIST_W   = 6,
  parameter bit          GSHARE   = 1'b1,
  parameter int          PC_W     = 32,
  parameter int          PC_SHIFT = 0,
  parameter int          INIT_CTR = 1,
  parameter logic [11:0] BEQ_OP   = 12'h018,
  parameter logic [11:0] BNE_OP   = 12'h019
) (
  input logic clk,
  input logic rst,
  gshare_branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_RST  = CTR_W'(INIT_CTR);

  logic [CTR_W-1:0]  ctr_tbl [0:ENTRIES-1];
  logic [HIST_W-1:0] ghr;
  logic [15:0]       mis_cnt;
  logic [IDX_W-1:0]  pc_bits;
  logic [IDX_W-1:0]  pred_idx;
  logic              dec_br;
  logic              com_br;
  logic              flush;
  logic              pred;

  assign dec_br   = (bp.Decoded_opcode == BEQ_OP) || (bp.Decoded_opcode == BNE_OP);
  assign com_br   = (bp.Commit_opcode  == BEQ_OP) || (bp.Commit_opcode  == BNE_OP);
  assign flush    = com_br & bp.Wrong_prediction;
  assign pc_bits  = bp.Decoded_PC[PC_SHIFT +: IDX_W];
  assign pred_idx = GSHARE ? (pc_bits ^ IDX_W'(ghr)) : pc_bits;
  // Read is ahead of the commit write in the same cycle, so decode sees the old value.
  assign pred     = dec_br & ctr_tbl[pred_idx][CTR_W-1] & ~rst;

  assign bp.predicted      = pred;
  assign bp.Predict_index  = pred_idx;
  assign bp.Predict_ghr    = ghr;
  assign bp.mispredict_cnt = mis_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_tbl[i] <= CTR_RST;
    end else if (com_br) begin
      if (bp.Commit_taken) begin
        if (ctr_tbl[bp.Commit_index] != CTR_MAX)
          ctr_tbl[bp.Commit_index] <= ctr_tbl[bp.Commit_index] + 1'b1;
      end else begin
        if (ctr_tbl[bp.Commit_index] != '0)
          ctr_tbl[bp.Commit_index] <= ctr_tbl[bp.Commit_index] - 1'b1;
      end
    end
  end

  // A flush rebuilds history from the committed snapshot and drops any decode shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (flush) begin
      ghr <= {bp.Commit_ghr[HIST_W-2:0], bp.Commit_taken};
    end else if (dec_br && !bp.Decode_stall) begin
      ghr <= {ghr[HIST_W-2:0], pred};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_cnt <= '0;
    end else if (flush && mis_cnt != 16'hFFFF) begin
      mis_cnt <= mis_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor (GSHARE=1, 64 x 2-bit counters, 6-bit GHR).
module tb_gshare_branch_predictor;
  localparam logic [11:0] BEQ = 12'h018;
  localparam logic [11:0] BNE = 12'h019;
  localparam logic [11:0] NOP = 12'h000;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  gshare_branch_predictor_if #(.IDX_W(6), .HIST_W(6), .PC_W(32)) bp ();

  gshare_branch_predictor #(
    .IDX_W(6), .CTR_W(2), .HIST_W(6), .GSHARE(1'b1), .PC_W(32),
    .PC_SHIFT(0), .INIT_CTR(1), .BEQ_OP(BEQ), .BNE_OP(BNE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp (bp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled later in the cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic [11:0] op, input logic [31:0] pc, input logic stall);
    bp.Decoded_opcode = op;
    bp.Decoded_PC     = pc;
    bp.Decode_stall   = stall;
  endtask

  task automatic com(input logic [11:0] op, input logic [5:0] idx, input logic [5:0] g,
                     input logic taken, input logic wrong);
    bp.Commit_opcode    = op;
    bp.Commit_index     = idx;
    bp.Commit_ghr       = g;
    bp.Commit_taken     = taken;
    bp.Wrong_prediction = wrong;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    dec(BEQ, 32'h10, 1'b1);
    com(NOP, 6'd0, 6'd0, 1'b0, 1'b0);
    #3;
    chk("rst_pred_low", 32'(bp.predicted), 32'd0);
    #9 rst = 1'b0;
    #2;
    // Test 1: reset state, GHR=0 so the index equals the PC bits
    chk("t1_pred", 32'(bp.predicted), 32'd0);
    chk("t1_index", 32'(bp.Predict_index), 32'h10);
    chk("t1_ghr", 32'(bp.Predict_ghr), 32'd0);
    chk("t1_ctr", 32'(dut.ctr_tbl[16]), 32'd1);
    chk("t1_miscnt", 32'(bp.mispredict_cnt), 32'd0);

    // Test 2: train idx 5 taken three times, saturating at 3
    tick();
    dec(NOP, 32'h0, 1'b1);
    com(BEQ, 6'd5, 6'd0, 1'b1, 1'b0);
    tick(); chk("t2_ctr_a", 32'(dut.ctr_tbl[5]), 32'd2);
    tick(); chk("t2_ctr_b", 32'(dut.ctr_tbl[5]), 32'd3);
    tick(); chk("t2_ctr_sat", 32'(dut.ctr_tbl[5]), 32'd3);
    com(NOP, 6'd0, 6'd0, 1'b0, 1'b0);
    dec(BEQ, 32'h5, 1'b1);
    #1;
    chk("t2_pred", 32'(bp.predicted), 32'd1);
    chk("t2_index", 32'(bp.Predict_index), 32'd5);

    // Test 3: bne not-taken four times: 3 -> 2,1,0,0
    com(BNE, 6'd5, 6'd0, 1'b0, 1'b0);
    tick(); chk("t3_ctr_a", 32'(dut.ctr_tbl[5]), 32'd2);
    chk("t3_pred_a", 32'(bp.predicted), 32'd1);
    tick(); chk("t3_ctr_b", 32'(dut.ctr_tbl[5]), 32'd1);
    chk("t3_pred_b", 32'(bp.predicted), 32'd0);
    tick(); chk("t3_ctr_c", 32'(dut.ctr_tbl[5]), 32'd0);
    tick(); chk("t3_ctr_floor", 32'(dut.ctr_tbl[5]), 32'd0);
    chk("t3_ghr_stalled", 32'(bp.Predict_ghr), 32'd0);
    // Wrong_prediction on a non-branch commit must be ignored entirely
    com(NOP, 6'd5, 6'd21, 1'b1, 1'b1);
    tick();
    chk("nb_ctr", 32'(dut.ctr_tbl[5]), 32'd0);
    chk("nb_ghr", 32'(bp.Predict_ghr), 32'd0);
    chk("nb_miscnt", 32'(bp.mispredict_cnt), 32'd0);

    // Test 4: prime idx 0x20, 0x21, 0x23 to taken, then decode three unstalled branches
    dec(NOP, 32'h0, 1'b0);
    com(BEQ, 6'h20, 6'd0, 1'b1, 1'b0); tick();
    com(BEQ, 6'h21, 6'd0, 1'b1, 1'b0); tick();
    com(BEQ, 6'h23, 6'd0, 1'b1, 1'b0); tick();
    com(NOP, 6'd0, 6'd0, 1'b0, 1'b0);
    dec(BEQ, 32'h20, 1'b0);
    #1;
    chk("t4_idx0", 32'(bp.Predict_index), 32'h20);
    chk("t4_pred0", 32'(bp.predicted), 32'd1);
    tick();
    chk("t4_idx1", 32'(bp.Predict_index), 32'h21);
    chk("t4_pred1", 32'(bp.predicted), 32'd1);
    tick();
    chk("t4_idx2", 32'(bp.Predict_index), 32'h23);
    chk("t4_pred2", 32'(bp.predicted), 32'd1);
    tick();
    chk("t4_ghr3", 32'(bp.Predict_ghr), 32'h07);
    bp.Decode_stall = 1'b1;
    #1;
    chk("t4_idx3", 32'(bp.Predict_index), 32'h27);
    chk("t4_pred_stall", 32'(bp.predicted), 32'd0);
    tick();
    chk("t4_ghr_held", 32'(bp.Predict_ghr), 32'h07);

    // Test 5: flush to 101010, then flush beats a concurrent unstalled decode
    dec(NOP, 32'h0, 1'b0);
    com(BNE, 6'h31, 6'b010101, 1'b0, 1'b1);
    tick();
    chk("t5_ghr_setup", 32'(bp.Predict_ghr), 32'b101010);
    chk("t5_miscnt_a", 32'(bp.mispredict_cnt), 32'd1);
    dec(BEQ, 32'h20, 1'b0);
    com(BNE, 6'h30, 6'b000011, 1'b0, 1'b1);
    tick();
    chk("t5_ghr_flush", 32'(bp.Predict_ghr), 32'b000110);
    chk("t5_miscnt_b", 32'(bp.mispredict_cnt), 32'd2);
    chk("t5_ctr_train", 32'(dut.ctr_tbl[48]), 32'd0);

    // Test 6: asynchronous reset between edges
    com(NOP, 6'd0, 6'd0, 1'b0, 1'b0);
    dec(BEQ, 32'h26, 1'b1);
    #1;
    chk("t6_pred_pre", 32'(bp.predicted), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_pred_rst", 32'(bp.predicted), 32'd0);
    chk("t6_ghr_rst", 32'(bp.Predict_ghr), 32'd0);
    #1 rst = 1'b0;
    tick();
    chk("t6_ctr20", 32'(dut.ctr_tbl[32]), 32'd1);
    chk("t6_ctr5", 32'(dut.ctr_tbl[5]), 32'd1);
    chk("t6_ctr30", 32'(dut.ctr_tbl[48]), 32'd1);
    chk("t6_miscnt", 32'(bp.mispredict_cnt), 32'd0);
    chk("t6_ghr", 32'(bp.Predict_ghr), 32'd0);
    chk("t6_pred_post", 32'(bp.predicted), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
